// File: rtl/ppu_render_timing_if.sv
`default_nettype none
//==============================================================================
// ppu_render_timing_if : register-block <-> render-timing signal bundle.
// Revision 1.0
//==============================================================================
interface ppu_render_timing_if;
    logic       background_EN;
    logic       sprite_EN;
    logic       interrupt_EN;
    logic       clearVerticalBlank;
    logic [8:0] dot;
    logic [8:0] scanline;
    logic       oddFrame;
    logic       isRendering;
    logic       incrementX;
    logic       incrementY;
    logic       resetX;
    logic       resetY;
    logic       clearSpriteFlags;
    logic       verticalBlankRegion;
    logic       nmi_N;

    // Register-block side: owns the enables, consumes timing and strobes.
    modport master (
        output background_EN, sprite_EN, interrupt_EN, clearVerticalBlank,
        input  dot, scanline, oddFrame, isRendering, incrementX, incrementY,
               resetX, resetY, clearSpriteFlags, verticalBlankRegion, nmi_N
    );

    modport slave (
        input  background_EN, sprite_EN, interrupt_EN, clearVerticalBlank,
        output dot, scanline, oddFrame, isRendering, incrementX, incrementY,
               resetX, resetY, clearSpriteFlags, verticalBlankRegion, nmi_N
    );
endinterface
`default_nettype wire

// File: rtl/ppu_render_timing.sv
`default_nettype none
//==============================================================================
// ppu_render_timing : NTSC dot/scanline counters, scroll strobes, vblank, NMI.
// Revision 1.0
//==============================================================================
module ppu_render_timing #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VBLANK_LINE     = 241,
    parameter int PRERENDER_LINE  = 261
) (
    input  logic               clk,
    input  logic               reset_n,
    ppu_render_timing_if.slave bus
);
    localparam logic [8:0] c_last_dot     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] c_last_line    = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] c_vbl_line     = 9'(VBLANK_LINE);
    localparam logic [8:0] c_pre_line     = 9'(PRERENDER_LINE);
    localparam logic [8:0] c_last_visible = 9'd239;
    localparam logic [8:0] c_flag_dot     = 9'd1;
    localparam logic [8:0] c_inc_x_first  = 9'd8;
    localparam logic [8:0] c_inc_y_dot    = 9'd256;
    localparam logic [8:0] c_prefetch_a   = 9'd328;
    localparam logic [8:0] c_prefetch_b   = 9'd336;
    localparam logic [8:0] c_reset_x_dot  = 9'd257;
    localparam logic [8:0] c_reset_y_lo   = 9'd280;
    localparam logic [8:0] c_reset_y_hi   = 9'd304;

    logic [8:0] dot_q, dot_d;
    logic [8:0] scanline_q, scanline_d;
    logic       odd_frame_q, odd_frame_d;
    logic       inc_x_q, inc_x_d;
    logic       inc_y_q, inc_y_d;
    logic       reset_x_q, reset_x_d;
    logic       reset_y_q, reset_y_d;
    logic       clr_spr_q, clr_spr_d;
    logic       vblank_q, vblank_d;
    logic       nmi_n_q, nmi_n_d;

    logic       w_rend;
    logic       w_skip;
    logic       w_vis_next;
    logic       w_gate_next;

    always_comb begin
        w_rend = bus.background_EN | bus.sprite_EN;
        w_skip = (scanline_q == c_pre_line) && (dot_q == (c_last_dot - 9'd1))
                 && odd_frame_q && w_rend;

        dot_d       = dot_q + 9'd1;
        scanline_d  = scanline_q;
        odd_frame_d = odd_frame_q;
        if (w_skip || (dot_q == c_last_dot)) begin
            dot_d = '0;
            if (w_skip || (scanline_q == c_last_line)) begin
                scanline_d  = '0;
                odd_frame_d = ~odd_frame_q;
            end else begin
                scanline_d = scanline_q + 9'd1;
            end
        end

        // Strobes decode the upcoming position so they line up with the
        // dot/scanline values the outputs will show after this edge.
        w_vis_next  = (scanline_d <= c_last_visible) || (scanline_d == c_pre_line);
        w_gate_next = w_rend & w_vis_next;

        inc_x_d   = w_gate_next &
                    (((dot_d[2:0] == 3'd0) && (dot_d >= c_inc_x_first) && (dot_d <= c_inc_y_dot))
                     || (dot_d == c_prefetch_a) || (dot_d == c_prefetch_b));
        inc_y_d   = w_gate_next & (dot_d == c_inc_y_dot);
        reset_x_d = w_gate_next & (dot_d == c_reset_x_dot);
        reset_y_d = w_gate_next & (scanline_d == c_pre_line)
                    & (dot_d >= c_reset_y_lo) & (dot_d <= c_reset_y_hi);
        clr_spr_d = (scanline_d == c_pre_line) && (dot_d == c_flag_dot);

        // A status read landing on the set edge wins, suppressing this frame's set.
        vblank_d = vblank_q;
        if (bus.clearVerticalBlank || ((scanline_d == c_pre_line) && (dot_d == c_flag_dot))) begin
            vblank_d = 1'b0;
        end else if ((scanline_d == c_vbl_line) && (dot_d == c_flag_dot)) begin
            vblank_d = 1'b1;
        end

        nmi_n_d = ~(vblank_q & bus.interrupt_EN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot_q       <= '0;
            scanline_q  <= c_pre_line;
            odd_frame_q <= 1'b0;
            inc_x_q     <= 1'b0;
            inc_y_q     <= 1'b0;
            reset_x_q   <= 1'b0;
            reset_y_q   <= 1'b0;
            clr_spr_q   <= 1'b0;
            vblank_q    <= 1'b0;
            nmi_n_q     <= 1'b1;
        end else begin
            dot_q       <= dot_d;
            scanline_q  <= scanline_d;
            odd_frame_q <= odd_frame_d;
            inc_x_q     <= inc_x_d;
            inc_y_q     <= inc_y_d;
            reset_x_q   <= reset_x_d;
            reset_y_q   <= reset_y_d;
            clr_spr_q   <= clr_spr_d;
            vblank_q    <= vblank_d;
            nmi_n_q     <= nmi_n_d;
        end
    end

    assign bus.dot                 = dot_q;
    assign bus.scanline            = scanline_q;
    assign bus.oddFrame            = odd_frame_q;
    assign bus.isRendering         = w_rend &
                                     ((scanline_q <= c_last_visible) || (scanline_q == c_pre_line));
    assign bus.incrementX          = inc_x_q;
    assign bus.incrementY          = inc_y_q;
    assign bus.resetX              = reset_x_q;
    assign bus.resetY              = reset_y_q;
    assign bus.clearSpriteFlags    = clr_spr_q;
    assign bus.verticalBlankRegion = vblank_q;
    assign bus.nmi_N               = nmi_n_q;
endmodule
`default_nettype wire

// File: tb/tb_ppu_render_timing.sv
`default_nettype none
//==============================================================================
// tb_ppu_render_timing : directed checks of counters, strobes, vblank and NMI.
// Revision 1.0
//==============================================================================
module tb_ppu_render_timing;
    logic clk     = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    ppu_render_timing_if bus_a ();
    ppu_render_timing_if bus_b ();

    // Full NTSC geometry for line-level behaviour.
    ppu_render_timing u_dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .bus     (bus_a)
    );

    // Short 8-line frame so frame wrap, odd skip and vblank recur quickly.
    ppu_render_timing #(
        .DOTS_PER_LINE   (341),
        .LINES_PER_FRAME (8),
        .VBLANK_LINE     (4),
        .PRERENDER_LINE  (7)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (rst_b_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int len, n_ry, ry_first, ry_last, n_clr, clr_dot;
        int nx, ny, y_dot, x_at_y, nrx, rx_dot, n_str, n_vbl, n_nmi;

        bus_a.background_EN = 1'b0; bus_a.sprite_EN = 1'b0;
        bus_a.interrupt_EN  = 1'b0; bus_a.clearVerticalBlank = 1'b0;
        bus_b.background_EN = 1'b0; bus_b.sprite_EN = 1'b0;
        bus_b.interrupt_EN  = 1'b0; bus_b.clearVerticalBlank = 1'b0;

        // ---------------- reset state ----------------
        tick(3);
        bus_a.background_EN = 1'b1;
        #1;
        check("rst_dot",      32'(bus_a.dot), 0);
        check("rst_scanline", 32'(bus_a.scanline), 261);
        check("rst_odd",      32'(bus_a.oddFrame), 0);
        check("rst_vbl",      32'(bus_a.verticalBlankRegion), 0);
        check("rst_nmi",      32'(bus_a.nmi_N), 1);
        check("rst_strobes",  32'({bus_a.incrementX, bus_a.incrementY, bus_a.resetX,
                                   bus_a.resetY, bus_a.clearSpriteFlags}), 0);
        check("rst_isrend",   32'(bus_a.isRendering), 1);
        rst_a_n = 1'b1;

        // ---------------- pre-render line, oddFrame=0, rendering on ----------------
        len = 0; n_ry = 0; ry_first = -1; ry_last = -1; n_clr = 0; clr_dot = -1;
        do begin
            @(negedge clk);
            len++;
            if (bus_a.scanline == 9'd261) begin
                if (bus_a.resetY) begin
                    n_ry++;
                    if (ry_first < 0) ry_first = int'(bus_a.dot);
                    ry_last = int'(bus_a.dot);
                end
                if (bus_a.clearSpriteFlags) begin
                    n_clr++;
                    clr_dot = int'(bus_a.dot);
                end
            end
        end while (bus_a.scanline != 9'd0 && len < 400);
        check("pre_even_len",  32'(len), 341);
        check("pre_ry_count",  32'(n_ry), 25);
        check("pre_ry_first",  32'(ry_first), 280);
        check("pre_ry_last",   32'(ry_last), 304);
        check("pre_clr_count", 32'(n_clr), 1);
        check("pre_clr_dot",   32'(clr_dot), 1);
        check("pre_odd_after", 32'(bus_a.oddFrame), 1);

        // ---------------- visible line 10 ----------------
        tick(10 * 341);
        check("l10_scanline", 32'(bus_a.scanline), 10);
        check("l10_dot",      32'(bus_a.dot), 0);
        nx = 0; ny = 0; y_dot = -1; x_at_y = 0; nrx = 0; rx_dot = -1; n_ry = 0;
        for (int i = 0; i < 341; i++) begin
            if (bus_a.scanline == 9'd10) begin
                if (bus_a.incrementX) nx++;
                if (bus_a.incrementY) begin
                    ny++;
                    y_dot  = int'(bus_a.dot);
                    x_at_y = int'(bus_a.incrementX);
                end
                if (bus_a.resetX) begin
                    nrx++;
                    rx_dot = int'(bus_a.dot);
                end
                if (bus_a.resetY) n_ry++;
            end
            @(negedge clk);
        end
        check("l10_incx_count", 32'(nx), 34);
        check("l10_incy_count", 32'(ny), 1);
        check("l10_incy_dot",   32'(y_dot), 256);
        check("l10_incx_at_y",  32'(x_at_y), 1);
        check("l10_rstx_count", 32'(nrx), 1);
        check("l10_rstx_dot",   32'(rx_dot), 257);
        check("l10_rsty_count", 32'(n_ry), 0);

        // ---------------- asynchronous reset mid-line ----------------
        tick(89 * 341 + 150);
        check("mid_scanline", 32'(bus_a.scanline), 100);
        check("mid_dot",      32'(bus_a.dot), 150);
        #1 rst_a_n = 1'b0;
        #1;
        check("async_dot",      32'(bus_a.dot), 0);
        check("async_scanline", 32'(bus_a.scanline), 261);
        check("async_odd",      32'(bus_a.oddFrame), 0);

        // ---------------- short frame, rendering off ----------------
        @(negedge clk);
        rst_b_n = 1'b1;
        n_str = 0;
        for (int i = 0; i < 8 * 341; i++) begin
            @(negedge clk);
            if (bus_b.incrementX | bus_b.incrementY | bus_b.resetX | bus_b.resetY) n_str++;
        end
        check("frm_scanline", 32'(bus_b.scanline), 7);
        check("frm_dot",      32'(bus_b.dot), 0);
        check("frm_odd",      32'(bus_b.oddFrame), 1);
        check("frm_strobes",  32'(n_str), 0);
        check("frm_vbl",      32'(bus_b.verticalBlankRegion), 1);
        check("frm_nmi",      32'(bus_b.nmi_N), 1);

        // ---------------- odd-frame skip on pre-render line ----------------
        bus_b.sprite_EN = 1'b1;
        len = 0;
        do begin
            @(negedge clk);
            len++;
        end while (bus_b.scanline != 9'd0 && len < 400);
        check("pre_odd_len",   32'(len), 340);
        check("pre_odd_dot",   32'(bus_b.dot), 0);
        check("pre_odd_flip",  32'(bus_b.oddFrame), 0);
        check("pre_vbl_clear", 32'(bus_b.verticalBlankRegion), 0);
        bus_b.sprite_EN = 1'b0;

        // ---------------- vblank set, NMI, clear pulse ----------------
        bus_b.interrupt_EN = 1'b1;
        tick(4 * 341);
        check("vb_pre_vbl", 32'(bus_b.verticalBlankRegion), 0);
        check("vb_pre_nmi", 32'(bus_b.nmi_N), 1);
        tick(1);
        check("vb_set_dot", 32'(bus_b.dot), 1);
        check("vb_set_vbl", 32'(bus_b.verticalBlankRegion), 1);
        check("vb_set_nmi", 32'(bus_b.nmi_N), 1);
        tick(1);
        check("vb_nmi_low", 32'(bus_b.nmi_N), 0);
        bus_b.clearVerticalBlank = 1'b1;
        tick(1);
        bus_b.clearVerticalBlank = 1'b0;
        check("vb_clr_vbl", 32'(bus_b.verticalBlankRegion), 0);
        check("vb_clr_nmi", 32'(bus_b.nmi_N), 0);
        tick(1);
        check("vb_clr_nmi_lat", 32'(bus_b.nmi_N), 1);
        check("vb_no_rearm",    32'(bus_b.verticalBlankRegion), 0);

        // ---------------- clear racing the set ----------------
        tick(8 * 341 - 4);
        check("race_scanline", 32'(bus_b.scanline), 4);
        check("race_dot",      32'(bus_b.dot), 0);
        bus_b.clearVerticalBlank = 1'b1;
        tick(1);
        bus_b.clearVerticalBlank = 1'b0;
        check("race_vbl", 32'(bus_b.verticalBlankRegion), 0);
        n_vbl = 0; n_nmi = 0;
        for (int i = 0; i < 3 * 341 - 1; i++) begin
            @(negedge clk);
            if (bus_b.verticalBlankRegion) n_vbl++;
            if (!bus_b.nmi_N) n_nmi++;
        end
        check("race_vbl_high", 32'(n_vbl), 0);
        check("race_nmi_low",  32'(n_nmi), 0);
        check("race_end_line", 32'(bus_b.scanline), 7);

        // ---------------- next frame sets normally; interrupt_EN re-arm ----------------
        tick(341 + 4 * 341 + 1);
        check("nxt_dot", 32'(bus_b.dot), 1);
        check("nxt_vbl", 32'(bus_b.verticalBlankRegion), 1);
        tick(1);
        check("nxt_nmi", 32'(bus_b.nmi_N), 0);
        bus_b.interrupt_EN = 1'b0;
        tick(1);
        check("ien_off_nmi", 32'(bus_b.nmi_N), 1);
        bus_b.interrupt_EN = 1'b1;
        tick(1);
        check("ien_on_nmi", 32'(bus_b.nmi_N), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ppu_render_timing.md
Name: ppu_render_timing

Overview:
- Dot/scanline timing generator for the PPU (NTSC 2C02 timing: 341 dots × 262 lines).
- Sits directly downstream of the CPU-facing register block and consumes its rendering enables, NMI enable and clearVerticalBlank pulse.
- Drives back into that block the scroll-counter strobes (incrementX/resetX/incrementY/resetY) and the verticalBlankRegion status bit.
- Also produces the NMI line, the sprite-flag clear strobe and the raw dot/scanline counters for the fetch pipeline.

Parameters:
- DOTS_PER_LINE, 341, dots per scanline (dot counter range 0..DOTS_PER_LINE-1).
- LINES_PER_FRAME, 262, scanlines per frame (scanline counter range 0..LINES_PER_FRAME-1).
- VBLANK_LINE, 241, scanline on which vblank is set.
- PRERENDER_LINE, 261, pre-render scanline; must equal LINES_PER_FRAME-1.

Ports:
- clk  input  1  PPU dot clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- background_EN  input  1  mask bit, background rendering enabled.
- sprite_EN  input  1  mask bit, sprite rendering enabled.
- interrupt_EN  input  1  control bit, NMI on vblank enabled.
- clearVerticalBlank  input  1  one-cycle pulse from the register block on a status read.
- dot  output  9  current dot, 0..340.
- scanline  output  9  current scanline, 0..261.
- oddFrame  output  1  toggles at each frame start.
- isRendering  output  1  rendering enabled and scanline is 0..239 or 261.
- incrementX  output  1  coarse-X increment strobe.
- incrementY  output  1  fine/coarse-Y increment strobe.
- resetX  output  1  copy horizontal bits from the temp address strobe.
- resetY  output  1  copy vertical bits from the temp address strobe.
- clearSpriteFlags  output  1  clear spriteCollision/spriteOverflow strobe.
- verticalBlankRegion  output  1  vblank status flag.
- nmi_N  output  1  active-low NMI request to the CPU.

Behaviour:
- Reset (async, reset_n=0):
  - dot=0, scanline=PRERENDER_LINE, oddFrame=0.
  - verticalBlankRegion=0, nmi_N=1, all strobes 0.
  - Counting resumes on the first rising edge after release.
- Counter update, each clk:
  - dot increments.
  - At dot 340: dot goes to 0 and scanline increments.
  - At scanline 261, dot 340: scanline goes to 0 and oddFrame toggles.
- Odd-frame skip:
  - Applies on scanline 261, dot 339, when oddFrame=1 and (background_EN|sprite_EN)=1, sampled that cycle.
  - Next state is scanline 0, dot 0 (dot 340 skipped); oddFrame toggles.
  - If rendering is disabled, no skip occurs.
- Define rend = background_EN | sprite_EN. Define vis = scanline<=239 or scanline==261.
- isRendering = rend & vis.
- Strobe timing:
  - All strobes are registered.
  - Each strobe is high for exactly one clk, in the cycle where the dot/scanline outputs show the listed value.
  - Strobes are gated by isRendering evaluated for that same cycle.
- Strobe decode:
  - incrementX: dot in {8,16,...,256} or dot in {328,336}. That is 34 pulses per line.
  - incrementY: dot==256, coincident with the dot-256 incrementX.
  - resetX: dot==257.
  - resetY: scanline==261 and dot 280..304 inclusive, high every cycle of that range (25 cycles).
  - clearSpriteFlags: scanline==261, dot==1. Not gated by rendering.
- Vblank flag:
  - Set: the flag is 1 starting in the cycle where the outputs show scanline==VBLANK_LINE, dot==1.
  - Clear: the flag is 0 starting in the cycle where the outputs show scanline==261, dot==1.
  - clearVerticalBlank=1 forces the flag to 0 on the next edge.
  - Race: if clearVerticalBlank=1 on the cycle the set would occur, the set is suppressed and the flag stays 0 for that frame.
  - A clear pulse at any other time clears only; a later set is not re-armed until the next frame.
- NMI:
  - nmi_N = ~(verticalBlankRegion & interrupt_EN), registered. Latency is 1 clk after either input changes.
  - Toggling interrupt_EN 0→1 while the flag=1 asserts NMI again.
- Simultaneous events: counter wrap, strobes and flag updates all act on the same edge without priority conflict. The clear-vs-set race is the only arbitrated case (clear wins).

Test Plan:
- Reset deassert, rendering off, run 89342 clks -> scanline/dot return to 261/0; oddFrame=1; zero inc/reset strobes observed.
- Rendering on (background_EN=1), one full visible line 10 -> exactly 34 incrementX, 1 incrementY at dot 256, 1 resetX at dot 257, 0 resetY.
- Rendering on, pre-render line -> resetY high dots 280..304 (25 cycles); clearSpriteFlags at dot 1; with oddFrame=1 the line is 340 clks long, with oddFrame=0 it is 341 clks.
- interrupt_EN=1, reach scanline 241 dot 1 -> verticalBlankRegion=1 that cycle, nmi_N=0 next cycle; pulse clearVerticalBlank -> flag 0, nmi_N=1 one clk later.
- clearVerticalBlank asserted on the cycle before the 241/1 set cycle -> flag never sets that frame, nmi_N stays 1; next frame sets normally.
- Assert reset_n=0 mid-line (scanline 100, dot 150) asynchronously -> outputs at reset values immediately, without waiting for a clk edge.
